// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory bus responder: FSM states, fault causes,
// default timeout and the request legality check.
package dmem_pkg;

  localparam int DATA_W          = 32;
  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    FAULT_NONE     = 3'd0,
    FAULT_ALIGN    = 3'd1,
    FAULT_CONFLICT = 3'd2,
    FAULT_ERR      = 3'd3,
    FAULT_TIMEOUT  = 3'd4
  } fault_e;

  // Classifies a request seen in IDLE; misalignment is reported ahead of a load/store conflict.
  function automatic fault_e req_fault(input logic [1:0] lsb, input logic ren, input logic wen);
    if (lsb != 2'b00)
      return FAULT_ALIGN;
    else if (ren && wen)
      return FAULT_CONFLICT;
    else
      return FAULT_NONE;
  endfunction

endpackage

// File: rtl/dmem_bus_responder_if.sv
// Single-master word bus with cyc/stb/ack handshake between the responder
// (master) and the bus/SRAM bridge (slave).
interface dmem_bus_responder_if import dmem_pkg::*; #(
  parameter int ADDR_W = 32
);
  logic              bus_cyc;
  logic              bus_stb;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_dout;
  logic [DATA_W-1:0] bus_din;
  logic              bus_ack;
  logic              bus_err;

  modport master (
    output bus_cyc, bus_stb, bus_we, bus_addr, bus_dout,
    input  bus_din, bus_ack, bus_err
  );

  modport slave (
    input  bus_cyc, bus_stb, bus_we, bus_addr, bus_dout,
    output bus_din, bus_ack, bus_err
  );
endinterface

// File: rtl/dmem_timeout_cnt.sv
// 8-bit clear/enable cycle counter; expired flags the last permitted bus cycle.
module dmem_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= 8'd0;
    else if (clr)
      cnt <= 8'd0;
    else if (en)
      cnt <= cnt + 8'd1;
  end

  assign expired = (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_bus_responder.sv
// MEM-stage data-memory responder: turns load/store requests into single word
// bus transfers, stalls the pipeline while they run and reports faults.
module dmem_bus_responder import dmem_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic              flush,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_stall,
  output logic              addr_fault,
  output logic              bus_fault,
  dmem_bus_responder_if.master bus
);

  state_e              state_q, state_d;
  fault_e              cause_q, req_cause;
  logic                flush_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                req, legal, expired, in_bus, finish;

  assign req       = mem_valid & (mem_ren | mem_wen) & ~flush;
  assign req_cause = req_fault(addr[1:0], mem_ren, mem_wen);
  assign legal     = req && (req_cause == FAULT_NONE);
  assign in_bus    = (state_q == BUS);
  assign finish    = bus.bus_ack | bus.bus_err | expired;

  dmem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_bus),
    .en      (in_bus),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mem_stall  = 1'b0;
    addr_fault = 1'b0;
    bus_fault  = 1'b0;
    rdata      = '0;
    case (state_q)
      IDLE: begin
        addr_fault = req && (req_cause != FAULT_NONE);
        if (legal) begin
          mem_stall = 1'b1;
          state_d   = BUS;
        end
      end
      BUS: begin
        mem_stall = 1'b1;
        if (finish)
          state_d = (flush || flush_q) ? DRAIN : DONE;
      end
      DONE: begin
        rdata     = rdata_q;
        bus_fault = (cause_q != FAULT_NONE);
        state_d   = IDLE;
      end
      DRAIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs read as zero for the whole reset cycle, whatever the MEM inputs show.
    if (rst) begin
      mem_stall  = 1'b0;
      addr_fault = 1'b0;
      bus_fault  = 1'b0;
      rdata      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_q <= 1'b0;
      cause_q <= FAULT_NONE;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          flush_q <= 1'b0;
          cause_q <= FAULT_NONE;
        end
        BUS: begin
          if (flush)
            flush_q <= 1'b1;
          if (bus.bus_ack) begin
            rdata_q <= we_q ? '0 : bus.bus_din;
            cause_q <= FAULT_NONE;
          end else if (bus.bus_err) begin
            rdata_q <= '0;
            cause_q <= FAULT_ERR;
          end else if (expired) begin
            rdata_q <= '0;
            cause_q <= FAULT_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && legal) begin
      addr_q  <= {addr[ADDR_W-1:2], 2'b00};
      wdata_q <= wdata;
      we_q    <= mem_wen;
    end
  end

  // Bus outputs come straight from registers and are zero outside BUS.
  assign bus.bus_cyc  = in_bus;
  assign bus.bus_stb  = in_bus;
  assign bus.bus_we   = in_bus & we_q;
  assign bus.bus_addr = in_bus ? addr_q  : '0;
  assign bus.bus_dout = in_bus ? wdata_q : '0;

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Bench for dmem_bus_responder: directed plan items followed by randomized
// transactions, checked cycle by cycle against a transaction-level model.
module tb_dmem_bus_responder;
  import dmem_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_ren, mem_wen, flush;
  logic [31:0] addr, wdata, rdata;
  logic        mem_stall, addr_fault, bus_fault;

  int ncmp  = 0;
  int nfail = 0;

  dmem_bus_responder_if #(.ADDR_W(32)) bus_if ();

  dmem_bus_responder #(.TIMEOUT(T), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_valid  (mem_valid),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .flush      (flush),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .mem_stall  (mem_stall),
    .addr_fault (addr_fault),
    .bus_fault  (bus_fault),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    chk1({tag, "_stall"}, mem_stall, 1'b0);
    chk1({tag, "_cyc"}, bus_if.bus_cyc, 1'b0);
    chk1({tag, "_stb"}, bus_if.bus_stb, 1'b0);
    chk1({tag, "_afault"}, addr_fault, 1'b0);
    chk1({tag, "_bfault"}, bus_fault, 1'b0);
    chk32({tag, "_rdata"}, rdata, 32'h0);
  endtask

  // resp: 0 = ack, 1 = err, 2 = silent; the response lands in BUS cycle wait_n.
  // flush_at: BUS cycle index where flush pulses, or -1 for none.
  task automatic txn(input logic ren, input logic wen, input logic [31:0] a,
                     input logic [31:0] wd, input int wait_n, input int resp,
                     input logic [31:0] din, input int flush_at);
    logic        req, fault, ok, drained, exp_bf;
    int          blen;
    logic [31:0] exp_rd;
    req     = ren | wen;
    fault   = req && ((a[1:0] != 2'b00) || (ren && wen));
    ok      = (resp == 0) && (wait_n < T);
    blen    = ((resp != 2) && (wait_n < T)) ? wait_n + 1 : T;
    drained = (flush_at >= 0) && (flush_at < blen);
    exp_rd  = (ok && ren && !wen && !drained) ? din : 32'h0;
    exp_bf  = !ok && !drained;

    @(negedge clk);
    mem_valid = 1'b1; mem_ren = ren; mem_wen = wen; addr = a; wdata = wd;
    flush = 1'b0; bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0;
    #1;
    chk1("req_stall", mem_stall, req && !fault);
    chk1("req_afault", addr_fault, fault);
    chk1("req_cyc", bus_if.bus_cyc, 1'b0);
    chk32("req_rdata", rdata, 32'h0);

    if (req && !fault) begin
      for (int i = 0; i < blen; i++) begin
        @(negedge clk);
        flush          = (i == flush_at);
        bus_if.bus_ack = (resp == 0) && (i == wait_n);
        bus_if.bus_err = (resp == 1) && (i == wait_n);
        bus_if.bus_din = bus_if.bus_ack ? din : $urandom;
        #1;
        chk1("bus_cyc", bus_if.bus_cyc, 1'b1);
        chk1("bus_stb", bus_if.bus_stb, 1'b1);
        chk1("bus_we", bus_if.bus_we, wen);
        chk32("bus_addr", bus_if.bus_addr, a & 32'hFFFF_FFFC);
        chk1("bus_stall", mem_stall, 1'b1);
        chk1("bus_bfault", bus_fault, 1'b0);
        chk32("bus_rdata", rdata, 32'h0);
        if (wen) chk32("bus_dout", bus_if.bus_dout, wd);
      end
      @(negedge clk);
      flush = 1'b0; bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0;
      #1;
      chk1("end_stall", mem_stall, 1'b0);
      chk1("end_cyc", bus_if.bus_cyc, 1'b0);
      chk1("end_stb", bus_if.bus_stb, 1'b0);
      chk32("end_rdata", rdata, exp_rd);
      chk1("end_bfault", bus_fault, exp_bf);
      chk1("end_afault", addr_fault, 1'b0);
    end

    @(negedge clk);
    mem_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
    #1;
    idle_check("after");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        r_ren, r_wen;
    logic [31:0] r_addr;
    int          kind, r_wait, r_resp, r_flush;

    rst = 1'b1; mem_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; flush = 1'b0;
    addr = '0; wdata = '0;
    bus_if.bus_din = '0; bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    idle_check("reset");
    chk1("reset_we", bus_if.bus_we, 1'b0);
    chk32("reset_addr", bus_if.bus_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    idle_check("post_reset");

    txn(1'b1, 1'b0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, -1);
    txn(1'b0, 1'b1, 32'h204, 32'h12345678, 3, 0, 32'hCAFEF00D, -1);
    txn(1'b1, 1'b0, 32'h102, 32'h0, 0, 0, 32'h11111111, -1);
    txn(1'b1, 1'b1, 32'h108, 32'h5, 0, 0, 32'h22222222, -1);
    txn(1'b1, 1'b0, 32'h110, 32'h0, 9, 2, 32'h33333333, -1);
    txn(1'b1, 1'b0, 32'h114, 32'h0, 1, 1, 32'h44444444, -1);
    txn(1'b1, 1'b0, 32'h118, 32'h0, 3, 0, 32'hA5A5A5A5, -1);
    txn(1'b1, 1'b0, 32'h120, 32'h0, 2, 0, 32'h55555555, 1);
    txn(1'b1, 1'b0, 32'h300, 32'h0, 0, 0, 32'h0BADF00D, -1);

    // Reset while a load waits on the bus.
    @(negedge clk);
    mem_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; addr = 32'h400;
    #1;
    chk1("abort_req_stall", mem_stall, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk1("abort_bus_cyc", bus_if.bus_cyc, 1'b1);
    end
    @(negedge clk);
    rst = 1'b1; mem_valid = 1'b0; mem_ren = 1'b0;
    @(negedge clk); #1;
    idle_check("abort_rst");
    chk1("abort_we", bus_if.bus_we, 1'b0);
    chk32("abort_addr", bus_if.bus_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    idle_check("abort_release");
    txn(1'b1, 1'b0, 32'h404, 32'h0, 1, 0, 32'h600DCAFE, -1);

    for (int k = 0; k < 24; k++) begin
      kind  = int'($urandom_range(0, 9));
      r_ren = (kind < 5) || (kind == 9);
      r_wen = (kind >= 5);
      if (kind == 8) begin r_ren = 1'b0; r_wen = 1'b0; end
      r_addr = $urandom & 32'h0000_FFFC;
      if ($urandom_range(0, 5) == 0) r_addr[1:0] = 2'($urandom_range(1, 3));
      r_wait = int'($urandom_range(0, 5));
      r_resp = int'($urandom_range(0, 2));
      r_flush = -1;
      if ($urandom_range(0, 3) == 0) r_flush = int'($urandom_range(0, 4));
      txn(r_ren, r_wen, r_addr, $urandom, r_wait, r_resp, $urandom, r_flush);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
